// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops FIFO words and sends each as a serial frame: start, DW data bits LSB first, optional even parity (FIFO_UART_TX_PARITY_EN), stop.
// Latency: ren_o pulses 1 cycle after empty_i is seen low in IDLE; the start bit begins 3 cycles after that sample.
// Backpressure: one word in flight; empty_i is ignored until the stop bit completes, so there is at most one pop per frame.
module fifo_uart_tx #(
    parameter int DW     = 4,
    parameter int CLKDIV = 434,
    parameter int CW     = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          empty_i,
    input  logic [DW-1:0] dat_i,
    output logic          ren_o,
    output logic          tx_o,
    output logic          busy_o,
    output logic [CW-1:0] sent_o
);
    localparam int DIVW = $clog2(CLKDIV);
    localparam int BW   = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLKDIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(DW - 1);

    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PAR, STOP} state_t;

    state_t          state_q, state_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic            ren_d, tx_d, busy_d;
    logic [CW-1:0]   sent_d;
    logic            bit_end;

    assign bit_end = (div_q == DIV_LAST);

`ifdef FIFO_UART_TX_PARITY_EN
    // Parity is taken from the word at load time because the shift register is consumed by DATA.
    logic par_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            par_q <= 1'b0;
        end else if (state_q == LOAD) begin
            par_q <= ^dat_i;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ren_o   <= 1'b0;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
            sent_o  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ren_o   <= ren_d;
            tx_o    <= tx_d;
            busy_o  <= busy_d;
            sent_o  <= sent_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ren_d   = 1'b0;
        tx_d    = tx_o;
        busy_d  = busy_o;
        sent_d  = sent_o;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!empty_i) begin
                    state_d = POP;
                    ren_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = dat_i;
                div_d   = '0;
                bit_d   = '0;
                tx_d    = 1'b0;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    div_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = PAR;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PAR: begin
                if (bit_end) begin
                    div_d   = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    div_d   = '0;
                    busy_d  = 1'b0;
                    sent_d  = sent_o + CW'(1);
                    state_d = IDLE;
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end
endmodule
